// File: rtl/calc_pkg.sv
// Shared types and arithmetic helpers for the calculation responder.
// Optional build macro: CALC_RSP_SAT_EN selects the saturating result.
package calc_pkg;

    typedef logic [7:0] operand_t;
    typedef logic [8:0] result_t;

    typedef struct packed {
        operand_t x;
        operand_t y;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full 9-bit sum, carry lands in bit 8.
    function automatic result_t full_sum(input operand_t x, input operand_t y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Sum clamped to 8'hFF; bit 8 is always zero.
    function automatic result_t sat_sum(input operand_t x, input operand_t y);
        result_t s;
        s = {1'b0, x} + {1'b0, y};
        return s[8] ? 9'h0FF : s;
    endfunction

endpackage

// File: rtl/calc_fifo.sv
// Synchronous request FIFO. Pointers carry one extra wrap bit so full and
// empty can be told apart without a separate counter.
module calc_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  req_t                     wdata,
    output req_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Store pushed entries.
    // NOTE: the array has no reset; an entry is only read after it has been written, and a resettable array cannot map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Advance the read and write pointers.
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/calc_responder.sv
// Responder end of the calculation request/response protocol: queues operand
// pairs, adds them with a fixed latency and returns results in order.
// Optional build macro: CALC_RSP_SAT_EN (saturate the result to 8'hFF).
module calc_responder
    import calc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_x,
    input  logic [7:0]               req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [8:0]               rsp_z,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    state_t      state;
    logic [1:0]  cnt;
    req_t        op_q;
    req_t        fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    function automatic result_t compute(input req_t r);
`ifdef CALC_RSP_SAT_EN
        return sat_sum(r.x, r.y);
`else
        return full_sum(r.x, r.y);
`endif
    endfunction

    // No pass-through: a full FIFO refuses even when a pop happens this cycle.
    assign req_ready = !fifo_full && !rst;
    assign push      = req_valid && req_ready;

    // The engine takes a new pair when idle, or straight after a handshake.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == DONE) && rsp_ready));

    assign busy = (state != IDLE) || (level != '0);

    calc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ('{x: req_x, y: req_y}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Engine: one operation in flight, result and valid held until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_z     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_q  <= fifo_rdata;
                        cnt   <= CNT_INIT;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == 2'd0) begin
                        rsp_z     <= compute(op_q);
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!fifo_empty) begin
                            op_q  <= fifo_rdata;
                            cnt   <= CNT_INIT;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_responder.sv
// Self-checking bench for calc_responder. Four instances (LATENCY 1..4) run
// side by side, each with its own request queue, against a queue/timestamp
// model of the protocol. Build with +define+CALC_RSP_SAT_EN for the
// saturating variant.
module tb_calc_responder;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int N     = 4;

    localparam logic [7:0] P6_X [6] = '{8'h01, 8'h10, 8'h7F, 8'hFF, 8'h33, 8'hAA};
    localparam logic [7:0] P6_Y [6] = '{8'h02, 8'h20, 8'h80, 8'h02, 8'h44, 8'h55};
    localparam logic [8:0] P6_F [6] = '{9'h003, 9'h030, 9'h0FF, 9'h101, 9'h077, 9'h0FF};
    localparam logic [8:0] P6_S [6] = '{9'h003, 9'h030, 9'h0FF, 9'h0FF, 9'h077, 9'h0FF};

    localparam logic [7:0] ST_X [8] = '{8'h00, 8'h01, 8'h80, 8'h12, 8'hFE, 8'hFF, 8'h0F, 8'h64};
    localparam logic [7:0] ST_Y [8] = '{8'h00, 8'h01, 8'h80, 8'h34, 8'h01, 8'h80, 8'hF0, 8'hC8};
    localparam logic [8:0] ST_F [8] = '{9'h000, 9'h002, 9'h100, 9'h046, 9'h0FF, 9'h17F, 9'h0FF, 9'h12C};
    localparam logic [8:0] ST_S [8] = '{9'h000, 9'h002, 9'h0FF, 9'h046, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};

    logic          clk;
    logic          rst;
    logic          rr;
    logic [N-1:0]  rv;
    logic [7:0]    rx [N];
    logic [7:0]    ry [N];
    logic [N-1:0]  dut_ready;
    logic [N-1:0]  dut_valid;
    logic [N-1:0]  dut_busy;
    logic [8:0]    dut_z [N];
    logic [LW-1:0] dut_level [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        calc_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (rv[g]),
            .req_ready (dut_ready[g]),
            .req_x     (rx[g]),
            .req_y     (ry[g]),
            .rsp_valid (dut_valid[g]),
            .rsp_ready (rr),
            .rsp_z     (dut_z[g]),
            .busy      (dut_busy[g]),
            .level     (dut_level[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected result from the arithmetic rule.
    function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y);
        int s;
        s = int'(x) + int'(y);
`ifdef CALC_RSP_SAT_EN
        if (s > 255) s = 255;
`endif
        return 9'(s);
    endfunction

    function automatic logic [8:0] pick(input logic [8:0] full_v, input logic [8:0] sat_v);
`ifdef CALC_RSP_SAT_EN
        return sat_v;
`else
        return full_v;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // Each instance: queue of waiting results, plus the one result being
    // computed and the edge from which it is visible.
    int         edge_n = 0;
    logic [8:0] m_pend [N][$];
    bit         m_act [N];
    int         m_vedge [N];
    logic [8:0] m_res [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_pend[k].delete();
                m_act[k] = 1'b0;
                m_vedge[k] = 0;
                m_res[k] = '0;
            end
        end else begin
            edge_n = edge_n + 1;
            for (int k = 0; k < N; k++) begin
                bit shown;
                bit accept;
                shown  = m_act[k] && (edge_n - 1 >= m_vedge[k]);
                accept = rv[k] && (m_pend[k].size() < DEPTH);
                if (shown && rr) m_act[k] = 1'b0;
                if (!m_act[k] && m_pend[k].size() != 0) begin
                    m_res[k]   = m_pend[k].pop_front();
                    m_act[k]   = 1'b1;
                    m_vedge[k] = edge_n + k + 1;
                end
                if (accept) m_pend[k].push_back(ref_sum(rx[k], ry[k]));
            end
        end
    end

    // ---------------- bench plumbing ----------------
    logic [15:0] tx_q [N][$];
    logic [8:0]  got [N][$];
    int          got_e [N][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        logic [15:0] h;
        for (int k = 0; k < N; k++) begin
            rv[k] = (tx_q[k].size() != 0);
            if (tx_q[k].size() != 0) begin
                h = tx_q[k][0];
                rx[k] = h[15:8];
                ry[k] = h[7:0];
            end
        end
    endtask

    task automatic enqueue(input logic [7:0] x, input logic [7:0] y);
        for (int k = 0; k < N; k++) tx_q[k].push_back({x, y});
        drive();
    endtask

    // Compare every instance against the model; log handshaken results.
    task automatic compare_all();
        bit ev;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                check($sformatf("rst_valid_L%0d", k + 1), 32'(dut_valid[k]), 32'd0);
                check($sformatf("rst_level_L%0d", k + 1), 32'(dut_level[k]), 32'd0);
                check($sformatf("rst_busy_L%0d", k + 1), 32'(dut_busy[k]), 32'd0);
                check($sformatf("rst_ready_L%0d", k + 1), 32'(dut_ready[k]), 32'd0);
            end else begin
                ev = m_act[k] && (edge_n >= m_vedge[k]);
                check($sformatf("valid_L%0d", k + 1), 32'(dut_valid[k]), 32'(ev));
                if (ev) check($sformatf("z_L%0d", k + 1), 32'(dut_z[k]), 32'(m_res[k]));
                check($sformatf("level_L%0d", k + 1), 32'(dut_level[k]), 32'(m_pend[k].size()));
                check($sformatf("busy_L%0d", k + 1), 32'(dut_busy[k]),
                      32'(m_act[k] || (m_pend[k].size() != 0)));
                check($sformatf("ready_L%0d", k + 1), 32'(dut_ready[k]),
                      32'(m_pend[k].size() < DEPTH));
                if (dut_valid[k] && rr) begin
                    got[k].push_back(dut_z[k]);
                    got_e[k].push_back(edge_n);
                end
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] took;
        @(negedge clk);
        compare_all();
        took = rv & dut_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (took[k]) void'(tx_q[k].pop_front());
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic check_got(input int k, input int idx, input logic [8:0] exp, input string name);
        if (got[k].size() > idx) check($sformatf("%s_L%0d", name, k + 1), 32'(got[k][idx]), 32'(exp));
        else check($sformatf("%s_L%0d_missing", name, k + 1), 32'(got[k].size()), 32'(idx + 1));
    endtask

    task automatic check_edge(input int k, input int idx, input int exp, input string name);
        if (got_e[k].size() > idx) check($sformatf("%s_L%0d", name, k + 1), 32'(got_e[k][idx]), 32'(exp));
        else check($sformatf("%s_L%0d_missing", name, k + 1), 32'(got_e[k].size()), 32'(idx + 1));
    endtask

    int base [N];
    int e0;

    task automatic mark();
        for (int k = 0; k < N; k++) base[k] = got[k].size();
        e0 = edge_n;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        rr  = 1'b1;
        rv  = '0;
        for (int k = 0; k < N; k++) begin
            rx[k] = '0;
            ry[k] = '0;
        end
        run(3);
        for (int k = 0; k < N; k++) check($sformatf("ready_in_reset_L%0d", k + 1), 32'(dut_ready[k]), 32'd0);
        rst = 1'b0;
        run(1);
        for (int k = 0; k < N; k++) check($sformatf("ready_after_reset_L%0d", k + 1), 32'(dut_ready[k]), 32'd1);

        // Single request: latency and sum.
        mark();
        enqueue(8'h05, 8'h03);
        run(10);
        for (int k = 0; k < N; k++) begin
            check_got(k, base[k], 9'h008, "sum_05_03");
            check_edge(k, base[k], e0 + k + 3, "latency");
            check($sformatf("idle_busy_L%0d", k + 1), 32'(dut_busy[k]), 32'd0);
        end

        // Carry / saturation corners.
        mark();
        enqueue(8'hFF, 8'h01);
        enqueue(8'hFF, 8'hFF);
        run(20);
        for (int k = 0; k < N; k++) begin
            check_got(k, base[k], pick(9'h100, 9'h0FF), "sum_ff_01");
            check_got(k, base[k] + 1, pick(9'h1FE, 9'h0FF), "sum_ff_ff");
        end

        // Back-pressure: 6 pairs with rsp_ready low.
        rr = 1'b0;
        mark();
        for (int i = 0; i < 6; i++) enqueue(P6_X[i], P6_Y[i]);
        run(8);
        for (int k = 0; k < N; k++) begin
            check($sformatf("full_level_L%0d", k + 1), 32'(dut_level[k]), 32'd4);
            check($sformatf("full_ready_L%0d", k + 1), 32'(dut_ready[k]), 32'd0);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                check($sformatf("stall_valid_L%0d", k + 1), 32'(dut_valid[k]), 32'd1);
                check($sformatf("stall_z_L%0d", k + 1), 32'(dut_z[k]), 32'h003);
            end
        end
        rr = 1'b1;
        run(40);
        for (int k = 0; k < N; k++) begin
            check($sformatf("drain_count_L%0d", k + 1), 32'(got[k].size() - base[k]), 32'd6);
            for (int i = 0; i < 6; i++) check_got(k, base[k] + i, pick(P6_F[i], P6_S[i]), $sformatf("order%0d", i));
        end

        // Reset with work in flight and two pairs queued.
        enqueue(8'h21, 8'h01);
        enqueue(8'h22, 8'h02);
        enqueue(8'h23, 8'h03);
        run(3);
        rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("async_rst_valid_L%0d", k + 1), 32'(dut_valid[k]), 32'd0);
            check($sformatf("async_rst_level_L%0d", k + 1), 32'(dut_level[k]), 32'd0);
            check($sformatf("async_rst_busy_L%0d", k + 1), 32'(dut_busy[k]), 32'd0);
            tx_q[k].delete();
        end
        drive();
        run(2);
        rst = 1'b0;
        mark();
        enqueue(8'h10, 8'h20);
        run(10);
        for (int k = 0; k < N; k++) begin
            check($sformatf("post_rst_count_L%0d", k + 1), 32'(got[k].size() - base[k]), 32'd1);
            check_got(k, base[k], 9'h030, "sum_10_20");
            check_edge(k, base[k], e0 + k + 3, "post_rst_latency");
        end

        // Streaming: spacing LATENCY+1, values in order.
        mark();
        for (int i = 0; i < 8; i++) enqueue(ST_X[i], ST_Y[i]);
        run(60);
        for (int k = 0; k < N; k++) begin
            check($sformatf("stream_count_L%0d", k + 1), 32'(got[k].size() - base[k]), 32'd8);
            for (int i = 0; i < 8; i++) check_got(k, base[k] + i, pick(ST_F[i], ST_S[i]), $sformatf("stream%0d", i));
            for (int i = 1; i < 8; i++) begin
                if (got_e[k].size() > base[k] + i)
                    check($sformatf("spacing%0d_L%0d", i, k + 1),
                          32'(got_e[k][base[k] + i] - got_e[k][base[k] + i - 1]), 32'(k + 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_responder.md
# calc_responder

Responder end of the calculation request/response protocol. It accepts operand pairs (x, y) from the initiator through a valid/ready request channel and queues them in a small FIFO. It computes the 9-bit sum with a configurable fixed latency and returns each result on a valid/ready response channel. A `busy` flag lets a polling initiator wait until the block has no work left.

## Interface
Parameters:
- DEPTH, 4, request FIFO depth; power of 2, ≥2
- LATENCY, 2, compute cycles per operation; 1..4

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  initiator presents an operand pair
- req_ready  out  1  FIFO can accept; equals !full, forced 0 while rst=1
- req_x  in  8  operand x
- req_y  in  8  operand y
- rsp_valid  out  1  result available
- rsp_ready  in  1  initiator consumes the result
- rsp_z  out  9  result
- busy  out  1  (state != IDLE) || (level != 0)
- level  out  $clog2(DEPTH)+1  number of queued requests

## Operation
- Request transfer: req_valid && req_ready at an edge pushes {req_x, req_y}. There is no pass-through: when the FIFO is full, req_ready=0 even if a pop occurs in the same cycle.
- Engine FSM, one operation in flight:
  - IDLE: if level != 0 → pop, latch operands, cnt := LATENCY-1, go to CALC.
  - CALC: if cnt == 0 → register rsp_z, rsp_valid := 1, go to DONE; otherwise cnt−−.
  - DONE: hold rsp_valid and rsp_z. On rsp_valid && rsp_ready:
    - FIFO non-empty → pop, go to CALC (back-to-back).
    - FIFO empty → rsp_valid := 0, go to IDLE.
- Arithmetic: rsp_z = {1'b0, x} + {1'b0, y}, 9 bits, never truncated (see Configuration).
- Ordering: responses are returned strictly in request order.
- Simultaneous push and pop on an empty FIFO: the pop sees empty, and the pushed entry is popped next cycle.
- rsp_z and rsp_valid must not change while rsp_valid && !rsp_ready.
- Reset mid-operation discards the in-flight operation and all queued requests.
- Reset values: req_ready=0 during reset and 1 after reset releases; rsp_valid=0; rsp_z=0; busy=0; level=0; state=IDLE; cnt=0.

## Timing
- Latency: request accepted at edge N into an empty FIFO with the engine IDLE → rsp_valid visible after edge N+1+LATENCY.
- Throughput with rsp_ready held at 1: one result every LATENCY+1 cycles. Each result has rsp_valid high for one cycle.
- req_ready, busy and level are derived only from registers, never combinationally from req_valid or rsp_ready.
- busy falls the cycle after the final response handshake, provided level=0.

## Configuration
- CALC_RSP_SAT_EN:
  - Defined: rsp_z = {1'b0, min(x+y, 8'hFF)}, i.e. saturating 8-bit result with bit 8 always 0.
  - Undefined: full 9-bit sum, carry in bit 8.
- Latency, handshakes and FIFO behaviour are identical in both builds.

## Structure
- calc_pkg holds:
  - operand_t (logic [7:0])
  - result_t (logic [8:0])
  - req_t (packed struct {x, y})
  - state_t enum {IDLE, CALC, DONE}
  - a saturating-sum function
- Sub-module calc_fifo: synchronous FIFO of req_t with parameter DEPTH, push/pop, full/empty/level outputs, async active-high rst. Pointers are $clog2(DEPTH) bits with an extra wrap bit.

## Test plan
- Reset, then x=8'h05, y=8'h03, rsp_ready=1 → rsp_z=9'h008 after edge N+1+LATENCY; busy=0 one cycle after the handshake.
- x=8'hFF, y=8'h01 → rsp_z=9'h100 without CALC_RSP_SAT_EN; 9'h0FF with it. x=8'hFF, y=8'hFF → 9'h1FE / 9'h0FF.
- rsp_ready=0, DEPTH=4, push 6 pairs back-to-back:
  - 5 accepted (one in the engine, 4 queued); level=4; req_ready=0; 6th held.
  - Raise rsp_ready → all results returned in order, and the 6th pair is accepted once space frees.
- rsp_ready held at 0 for 10 cycles during DONE → rsp_valid=1 and rsp_z stable throughout.
- Assert rst during CALC with 2 entries queued:
  - Outputs immediately (asynchronously) become rsp_valid=0, level=0, busy=0.
  - After release, x=8'h10, y=8'h20 → rsp_z=9'h030 with nominal latency.
- 8 streaming requests, rsp_ready=1, LATENCY=1..4 → responses spaced exactly LATENCY+1 cycles, sums correct.
